// File: rtl/pipe_scoreboard_ctrl.sv
// Hazard/interlock controller for a 5-stage in-order pipeline: scoreboard, forwarding, load-use stall, freeze, branch flush.
// Optional macro PIPE_SCB_PERF_CNT_EN adds saturating stall/freeze/flush performance counters.
module pipe_scoreboard_ctrl #(
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int DEPTH    = 3,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_reg_write,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    input  logic              ext_stall,
`ifdef PIPE_SCB_PERF_CNT_EN
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  freeze_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
`endif
    output logic              issue,
    output logic              stall,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel
);

    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] rd;
        logic              ld;
    } entry_t;

    entry_t            sb_reg [DEPTH];
    logic [DEPTH-1:0]  match_a;
    logic [DEPTH-1:0]  match_b;
    logic              lu_stall;

    generate
        if (NUM_REGS != (1 << ADDR_W) || DEPTH < 2 || CNT_W < 1) begin : g_bad_cfg
            $error("pipe_scoreboard_ctrl: illegal parameter combination");
        end
    endgenerate

    // Entry 0 is the instruction in EX; higher indices are older instructions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_reg[k] <= '0;
            end
        end else if (!ext_stall) begin
            sb_reg[0].v  <= issue && id_reg_write && (id_rd != '0);
            sb_reg[0].rd <= id_rd;
            sb_reg[0].ld <= id_mem_read;
            for (int k = 1; k < DEPTH; k++) begin
                sb_reg[k] <= sb_reg[k-1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match_a[gi] = sb_reg[gi].v && (sb_reg[gi].rd == id_rs) && id_uses_rs && (id_rs != '0);
            assign match_b[gi] = sb_reg[gi].v && (sb_reg[gi].rd == id_rt) && id_uses_rt && (id_rt != '0);
        end
    endgenerate

    assign lu_stall = (match_a[0] || match_b[0]) && sb_reg[0].ld;

    // Walk from oldest to youngest so the youngest (lowest k) producer wins.
    always_comb begin
        fwd_a_sel = 2'd0;
        fwd_b_sel = 2'd0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match_a[k]) begin
                fwd_a_sel = (k == 0) ? (sb_reg[0].ld ? 2'd0 : 2'd1) : ((k == 1) ? 2'd2 : 2'd0);
            end
            if (match_b[k]) begin
                fwd_b_sel = (k == 0) ? (sb_reg[0].ld ? 2'd0 : 2'd1) : ((k == 1) ? 2'd2 : 2'd0);
            end
        end
    end

    always_comb begin
        issue       = 1'b0;
        stall       = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (ext_stall) begin
            // Branch stays in EX while frozen, so its flush simply waits.
            stall = 1'b1;
        end else if (ex_branch_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (lu_stall) begin
            stall       = 1'b1;
            flush_id_ex = 1'b1;
        end else begin
            issue = id_valid;
        end
    end

`ifdef PIPE_SCB_PERF_CNT_EN
    // flush_cnt counts branch-flush cycles (both pipeline registers squashed).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt  <= '0;
            freeze_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (lu_stall && !ext_stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (ext_stall && freeze_cnt != '1) begin
                freeze_cnt <= freeze_cnt + 1'b1;
            end
            if (flush_if_id && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_scoreboard_ctrl.sv
// Bench for pipe_scoreboard_ctrl: directed vector table, mid-stream reset, then random traffic vs. a history-queue model.
module tb_pipe_scoreboard_ctrl;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              id_valid = 1'b0;
    logic [ADDR_W-1:0] id_rs = '0;
    logic [ADDR_W-1:0] id_rt = '0;
    logic              id_uses_rs = 1'b0;
    logic              id_uses_rt = 1'b0;
    logic              id_reg_write = 1'b0;
    logic [ADDR_W-1:0] id_rd = '0;
    logic              id_mem_read = 1'b0;
    logic              ex_branch_taken = 1'b0;
    logic              ext_stall = 1'b0;
    logic              issue, stall, flush_if_id, flush_id_ex;
    logic [1:0]        fwd_a_sel, fwd_b_sel;

    int total = 0;
    int bad   = 0;

    pipe_scoreboard_ctrl #(.ADDR_W(ADDR_W), .NUM_REGS(32), .DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
        .id_rd(id_rd), .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
        .ext_stall(ext_stall), .issue(issue), .stall(stall), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              vl;
        logic [ADDR_W-1:0] rs, rt, rd;
        bit              urs, urt, rw, mr, br, xs;
        logic [7:0]      exp;
    } vec_t;

    typedef struct {
        bit w;
        int rd;
        bit ld;
    } hist_t;

    hist_t hist[$];   // hist[i] = instruction i advancing steps past EX (most recent first)
    vec_t  tbl[$];

    function automatic logic [7:0] ex(bit i, bit s, bit fi, bit fe, int fa, int fb);
        return {i, s, fi, fe, 2'(fa), 2'(fb)};
    endfunction

    function automatic vec_t mk(bit vl, int rs, int rt, bit urs, bit urt, bit rw, int rd,
                                bit mr, bit br, bit xs, logic [7:0] e);
        vec_t v;
        v.vl = vl; v.rs = 5'(rs); v.rt = 5'(rt); v.urs = urs; v.urt = urt;
        v.rw = rw; v.rd = 5'(rd); v.mr = mr; v.br = br; v.xs = xs; v.exp = e;
        return v;
    endfunction

    function automatic logic [7:0] got_outs();
        return {issue, stall, flush_if_id, flush_id_ex, fwd_a_sel, fwd_b_sel};
    endfunction

    task automatic drive(vec_t v);
        id_valid = v.vl; id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
        id_reg_write = v.rw; id_rd = v.rd; id_mem_read = v.mr;
        ex_branch_taken = v.br; ext_stall = v.xs;
    endtask

    task automatic check(string nm, logic [7:0] got, logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got {iss,stl,fif,fie,fa,fb}=%b required=%b", nm, got, exp);
        end else begin
            $display("ok   %s: {iss,stl,fif,fie,fa,fb}=%b", nm, got);
        end
    endtask

    // Called at posedge+1: drive, compare at the falling edge, advance to next posedge+1.
    task automatic step(string nm, vec_t v);
        drive(v);
        @(negedge clk);
        check(nm, got_outs(), v.exp);
        @(posedge clk);
        #1;
    endtask

    function automatic int find_src(int s, bit used);
        for (int i = 0; i < hist.size() && i < DEPTH; i++) begin
            if (used && s != 0 && hist[i].w && hist[i].rd == s) return i;
        end
        return -1;
    endfunction

    function automatic int sel_for(int k);
        if (k == 0) return hist[0].ld ? 0 : 1;
        if (k == 1) return 2;
        return 0;
    endfunction

    function automatic logic [7:0] model(vec_t v, output bit iss);
        int  ka, kb;
        bit  lu;
        bit  s, fi, fe;
        ka = find_src(int'(v.rs), v.urs);
        kb = find_src(int'(v.rt), v.urt);
        lu = (ka == 0 || kb == 0) && hist[0].ld;
        iss = 0; s = 0; fi = 0; fe = 0;
        if (v.xs) s = 1;
        else if (v.br) begin fi = 1; fe = 1; end
        else if (lu) begin s = 1; fe = 1; end
        else iss = v.vl;
        return ex(iss, s, fi, fe, sel_for(ka), sel_for(kb));
    endfunction

    task automatic model_advance(vec_t v, bit iss);
        hist_t h;
        if (v.xs) return;
        h.w = iss && v.rw && (v.rd != 0);
        h.rd = int'(v.rd);
        h.ld = v.mr;
        hist.push_front(h);
        while (hist.size() > DEPTH) void'(hist.pop_back());
    endtask

    initial begin
        vec_t v;
        bit   iss;

        // Directed table from a cold start; expected values derived by hand.
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0)));
        tbl.push_back(mk(1, 1, 2, 1, 1, 1, 3, 0, 0, 0, ex(1,0,0,0,0,0)));   // add $3,$1,$2
        tbl.push_back(mk(1, 3, 5, 1, 1, 1, 4, 0, 0, 0, ex(1,0,0,0,1,0)));   // sub $4,$3,$5
        tbl.push_back(mk(1, 3, 4, 1, 1, 1, 6, 0, 0, 0, ex(1,0,0,0,2,1)));
        tbl.push_back(mk(1, 3, 6, 1, 1, 1, 7, 0, 0, 0, ex(1,0,0,0,0,1)));   // $3 at k=2 -> regfile
        tbl.push_back(mk(1, 1, 0, 1, 0, 1, 5, 1, 0, 0, ex(1,0,0,0,0,0)));   // lw $5
        tbl.push_back(mk(1, 5, 7, 1, 1, 1, 6, 0, 0, 0, ex(0,1,0,1,0,2)));   // load-use
        tbl.push_back(mk(1, 5, 7, 1, 1, 1, 6, 0, 0, 0, ex(1,0,0,0,2,0)));
        tbl.push_back(mk(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, ex(1,0,0,0,0,0)));   // addi $0
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 8, 0, 0, 0, ex(1,0,0,0,0,0)));   // read $0
        tbl.push_back(mk(1, 8, 0, 1, 0, 1, 9, 1, 0, 0, ex(1,0,0,0,1,0)));   // lw $9
        tbl.push_back(mk(1, 9, 8, 1, 1, 1, 10, 0, 1, 0, ex(0,0,1,1,0,2)));  // branch beats load-use
        tbl.push_back(mk(1, 10, 9, 1, 1, 1, 11, 0, 0, 0, ex(1,0,0,0,0,2))); // entry0 was a bubble
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0)));
        tbl.push_back(mk(1, 1, 2, 1, 1, 1, 3, 0, 0, 0, ex(1,0,0,0,0,0)));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 3, 5, 1, 1, 1, 4, 0, 0, 1, ex(0,1,0,0,1,0))); // freeze
        tbl.push_back(mk(1, 3, 5, 1, 1, 1, 4, 0, 0, 0, ex(1,0,0,0,1,0)));
        tbl.push_back(mk(1, 3, 4, 1, 1, 1, 6, 0, 0, 0, ex(1,0,0,0,2,1)));
        tbl.push_back(mk(1, 6, 1, 1, 1, 1, 7, 0, 1, 1, ex(0,1,0,0,1,0)));   // branch under freeze
        tbl.push_back(mk(1, 6, 1, 1, 1, 1, 7, 0, 1, 1, ex(0,1,0,0,1,0)));
        tbl.push_back(mk(1, 6, 1, 1, 1, 1, 7, 0, 1, 0, ex(0,0,1,1,1,0)));   // flush after release
        tbl.push_back(mk(1, 6, 7, 1, 1, 1, 8, 0, 0, 0, ex(1,0,0,0,2,0)));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, ex(1,0,0,0,0,0)));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 10, 0, 0, 0, ex(1,0,0,0,0,0)));

        repeat (2) @(posedge clk);
        #1;
        check("in_reset", got_outs(), 8'h00);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

        // Mid-stream reset with three live entries ($10,$9,$8).
        drive(mk(0, 10, 9, 1, 1, 0, 0, 0, 0, 0, 8'h00));
        @(negedge clk);
        check("pre_reset_fwd", got_outs(), ex(0,0,0,0,1,2));
        #1 reset = 1'b0;
        #1 check("async_reset", got_outs(), 8'h00);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        step("cold_pair0", mk(1, 9, 0, 1, 0, 1, 10, 0, 0, 0, ex(1,0,0,0,0,0)));
        step("cold_pair1", mk(1, 10, 0, 1, 0, 1, 11, 0, 0, 0, ex(1,0,0,0,1,0)));

        // Random traffic against the history-queue model.
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
        @(negedge clk);
        reset = 1'b0;
        hist.delete();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 400; n++) begin
            v.vl  = ($urandom_range(0, 7) != 0);
            v.rs  = 5'($urandom_range(0, 7));
            v.rt  = 5'($urandom_range(0, 7));
            v.urs = v.vl && ($urandom_range(0, 3) != 0);
            v.urt = v.vl && ($urandom_range(0, 1) != 0);
            v.rw  = ($urandom_range(0, 3) != 0);
            v.rd  = 5'($urandom_range(0, 7));
            v.mr  = v.rw && ($urandom_range(0, 2) == 0);
            v.br  = ($urandom_range(0, 9) == 0);
            v.xs  = ($urandom_range(0, 7) == 0);
            v.exp = model(v, iss);
            step($sformatf("rnd%0d", n), v);
            model_advance(v, iss);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_scoreboard_ctrl.md
Name: pipe_scoreboard_ctrl

Overview:
Parametrised hazard and interlock controller for the in-order MIPS-style pipeline (IF, ID, EX, DM, WB).
- Tracks every in-flight destination register in a shift-register scoreboard.
- Generates operand-forwarding selects, load-use stalls, external freeze and branch flushes for the instruction currently in ID.
- Replaces the hard-wired stall flags that today pass between the IF, ID and EX stages.

Parameters:
ADDR_W, 5, register address width
NUM_REGS, 32, architectural register count (2**ADDR_W)
DEPTH, 3, scoreboard entries: instructions tracked beyond ID (EX, DM, WB, ...); minimum 2
CNT_W, 32, performance counter width (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; clears all state
id_valid  in  1  ID holds a real instruction
id_rs  in  ADDR_W  source register 1
id_rt  in  ADDR_W  source register 2
id_uses_rs  in  1  rs is read
id_uses_rt  in  1  rt is read
id_reg_write  in  1  instruction writes id_rd
id_rd  in  ADDR_W  destination register
id_mem_read  in  1  instruction is a load
ex_branch_taken  in  1  branch resolved taken in EX this cycle
ext_stall  in  1  data memory not ready; freeze the whole pipeline
issue  out  1  ID instruction advances into EX this cycle
stall  out  1  hold PC and IF/ID
flush_if_id  out  1  squash the IF/ID contents
flush_id_ex  out  1  insert a bubble into ID/EX
fwd_a_sel  out  2  rs operand source: 0 = register file, 1 = EX/DM result, 2 = DM/WB result
fwd_b_sel  out  2  rt operand source, same encoding as fwd_a_sel

Behaviour:
- Scoreboard: entry[k] = {v, rd, ld}, k = 0..DEPTH-1. Entry[0] is the instruction in EX; entry[k] is k stages past EX.
- Update on each rising edge when ext_stall=0:
  - entry[k+1] <= entry[k].
  - entry[0] <= {issue & id_reg_write & (id_rd != 0), id_rd, id_mem_read}.
  - The last entry drops off the end.
- When ext_stall=1, all entries hold.
- Match on entry k for source s: entry[k].v && entry[k].rd == s && the source is used && s != 0. The lowest k that matches wins.
- Forwarding (combinational; the datapath registers it into ID/EX with the instruction):
  - match at k=0, non-load: sel = 1.
  - match at k=1: sel = 2.
  - match at k ≥ 2: sel = 0 (register file writes before it reads).
  - no match: sel = 0.
- Load-use: a match at k=0 with ld=1 sets lu_stall=1, and that source's sel = 0. The next cycle the load sits at k=1, so sel = 2.
- Output priority, highest first:
  1. ext_stall=1: stall=1, issue=0, both flushes=0. A pending branch flush is deferred until ext_stall falls, because the branch stays in EX.
  2. ex_branch_taken=1: flush_if_id=1, flush_id_ex=1, issue=0, stall=0.
  3. lu_stall=1: stall=1, flush_id_ex=1 (bubble), issue=0.
  4. Otherwise: issue = id_valid; stall and both flushes = 0.
- Outputs are purely combinational from the inputs and the scoreboard. There is no added latency.
- Reset (asynchronous assert, synchronous release): all entries have v=0. With id_valid=0 every output is 0. Reset in the middle of operation discards all in-flight tracking at once.
- Register 0 never creates a hazard and is never tracked.
- DEPTH > 3 covers longer back-ends. Entries at k ≥ 2 still use register-file data.

Optional Feature:
Macro PIPE_SCB_PERF_CNT_EN enables three extra outputs, each CNT_W wide:
- stall_cnt: cycles with lu_stall=1 and ext_stall=0.
- freeze_cnt: cycles with ext_stall=1.
- flush_cnt: cycles with flushes asserted.

Counter rules:
- Each counter saturates at all-ones.
- Each clears on reset.

Without the macro these ports and the counter logic are absent, and the rest of the behaviour is identical.

Test Plan:
- Distance-1 forward: add $3,$1,$2 issued, then sub $4,$3,$5 in ID -> fwd_a_sel=1, stall=0, issue=1. One cycle later, a further use of $3 -> sel=2.
- Load-use: lw $5,0($1) then add $6,$5,$7 -> one cycle with stall=1, flush_id_ex=1, issue=0. The next cycle gives fwd_a_sel=2, issue=1. With the macro enabled, stall_cnt=1.
- $0 destination: addi $0,$1,4 followed by a read of $0 -> fwd selects 0, no stall.
- Branch taken with a load-use pending in ID -> flush_if_id=flush_id_ex=1, stall=0. Entry[0] is a bubble next cycle.
- ext_stall held for 3 cycles with a dependent pair in flight:
  - During the freeze: stall=1, scoreboard frozen, fwd selects unchanged.
  - After release: forwarding resumes exactly as without the freeze.
  - ex_branch_taken asserted during the freeze flushes only after release.
- reset driven low mid-stream with 3 valid entries -> all outputs 0 immediately. After release, a dependent pair behaves as if from a cold start.
